// File: rtl/pe_int_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_int_pkg
// Purpose  : Shared definitions for the integer SIMD processing element:
//            mode encodings, lane-count helper and saturation-bound helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pe_int_pkg;

    // SIMD operand modes; 2'b11 aliases int32.
    localparam logic [1:0] MODE_INT8  = 2'b00;
    localparam logic [1:0] MODE_INT16 = 2'b01;
    localparam logic [1:0] MODE_INT32 = 2'b10;

    // Working width of the saturation-bound helpers; supports ACC_W up to 255.
    localparam int c_SAT_W = 257;

    // Number of lanes packed into a DATA_W-bit operand for a given mode.
    function automatic int lanes(input logic [1:0] mode, input int data_w);
        case (mode)
            MODE_INT8:  return data_w / 8;
            MODE_INT16: return data_w / 16;
            MODE_INT32: return 1;
            default:    return 1;
        endcase
    endfunction

    // Largest representable accumulator value, as an (acc_w+1)-bit pattern
    // in the low bits of the returned vector.
    function automatic logic [c_SAT_W-1:0] sat_max(input int acc_w, input logic sgn);
        logic [c_SAT_W-1:0] w_one;
        w_one = c_SAT_W'(1);
        return sgn ? ((w_one << (acc_w - 1)) - w_one) : ((w_one << acc_w) - w_one);
    endfunction

    // Smallest representable accumulator value (two's complement for signed).
    function automatic logic [c_SAT_W-1:0] sat_min(input int acc_w, input logic sgn);
        logic [c_SAT_W-1:0] w_one;
        w_one = c_SAT_W'(1);
        return sgn ? (~(w_one << (acc_w - 1)) + w_one) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_simd_mul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_simd_mul
// Purpose  : Second pipeline stage of the PE. Splits the packed operands into
//            int8 / int16 / int32 lanes, multiplies each lane pair with sign
//            or zero extension, reduces the lane products to one sum and
//            registers it together with the beat tags.
// Ports    : clk, rst_n            - clock, async active-low reset
//            i_valid/i_first/i_last - beat valid and dot-product tags
//            i_mode, i_sgn          - lane mode and signedness of this beat
//            i_row, i_col           - packed operands, lane 0 in the LSBs
//            o_valid/o_first/o_last/o_sgn - registered tags
//            o_sum                  - registered ACC_W+1-bit lane sum
// Revision : 1.0 - initial release
// ============================================================================
module pe_simd_mul
    import pe_int_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_first,
    input  logic              i_last,
    input  logic [1:0]        i_mode,
    input  logic              i_sgn,
    input  logic [DATA_W-1:0] i_row,
    input  logic [DATA_W-1:0] i_col,
    output logic              o_valid,
    output logic              o_first,
    output logic              o_last,
    output logic              o_sgn,
    output logic [ACC_W:0]    o_sum
);

    localparam int c_SUM_W = ACC_W + 1;
    localparam int c_N8    = lanes(MODE_INT8, DATA_W);
    localparam int c_N16   = lanes(MODE_INT16, DATA_W);

    // Lane products are formed at the full sum width: the operands are
    // extended first, so the modular product equals the exact product.
    logic [c_SUM_W-1:0] w_p8 [c_N8];
    logic [c_SUM_W-1:0] w_sum8;
    logic [c_SUM_W-1:0] w_sum16;
    logic [c_SUM_W-1:0] w_p32;
    logic [c_SUM_W-1:0] w_sel;

    for (genvar g = 0; g < c_N8; g++) begin : g_lane8
        logic [8:0] w_a;
        logic [8:0] w_b;
        assign w_a     = {i_sgn & i_row[8*g+7], i_row[8*g +: 8]};
        assign w_b     = {i_sgn & i_col[8*g+7], i_col[8*g +: 8]};
        assign w_p8[g] = {{(c_SUM_W-9){w_a[8]}}, w_a} * {{(c_SUM_W-9){w_b[8]}}, w_b};
    end

    always_comb begin
        w_sum8 = '0;
        for (int i = 0; i < c_N8; i++) begin
            w_sum8 = w_sum8 + w_p8[i];
        end
    end

    if (c_N16 > 0) begin : g_has16
        logic [c_SUM_W-1:0] w_p16 [c_N16];
        for (genvar g = 0; g < c_N16; g++) begin : g_lane16
            logic [16:0] w_a;
            logic [16:0] w_b;
            assign w_a      = {i_sgn & i_row[16*g+15], i_row[16*g +: 16]};
            assign w_b      = {i_sgn & i_col[16*g+15], i_col[16*g +: 16]};
            assign w_p16[g] = {{(c_SUM_W-17){w_a[16]}}, w_a} * {{(c_SUM_W-17){w_b[16]}}, w_b};
        end
        always_comb begin
            w_sum16 = '0;
            for (int i = 0; i < c_N16; i++) begin
                w_sum16 = w_sum16 + w_p16[i];
            end
        end
    end else begin : g_no16
        // Operands narrower than 16 bits hold no int16 lane.
        assign w_sum16 = '0;
    end

    // Single full-width lane.
    logic [DATA_W:0] w_a32;
    logic [DATA_W:0] w_b32;
    assign w_a32 = {i_sgn & i_row[DATA_W-1], i_row};
    assign w_b32 = {i_sgn & i_col[DATA_W-1], i_col};
    assign w_p32 = {{(c_SUM_W-DATA_W-1){w_a32[DATA_W]}}, w_a32}
                 * {{(c_SUM_W-DATA_W-1){w_b32[DATA_W]}}, w_b32};

    always_comb begin
        case (i_mode)
            MODE_INT8:  w_sel = w_sum8;
            MODE_INT16: w_sel = w_sum16;
            default:    w_sel = w_p32;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            o_sgn   <= 1'b0;
            o_sum   <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_first <= i_first;
                o_last  <= i_last;
                o_sgn   <= i_sgn;
                o_sum   <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_int_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pe_int_mac
// Purpose  : Systolic integer processing element. Runtime-selectable SIMD
//            int8/int16/int32 dot-product MAC over k_len beats, signed or
//            unsigned, with a saturating accumulator and registered
//            forwarding of the row/col operands.
// Ports    : clk, rst_n             - clock, async active-low reset
//            load_in                - operand beat valid (no backpressure)
//            mode, is_signed, k_len - dot-product setup, sampled on FIRST beat
//            row_in, col_in         - packed operands
//            row_out, col_out, load_out - 1-cycle registered forwarding
//            pe_result, overflow    - result and sticky saturation flag
//            done_pe                - one-cycle result strobe
//            busy                   - dot product or beats in flight
// Revision : 1.0 - initial release
// ============================================================================
module pe_int_mac
    import pe_int_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int KLEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_in,
    input  logic [1:0]        mode,
    input  logic              is_signed,
    input  logic [KLEN_W-1:0] k_len,
    input  logic [DATA_W-1:0] row_in,
    input  logic [DATA_W-1:0] col_in,
    output logic [DATA_W-1:0] row_out,
    output logic [DATA_W-1:0] col_out,
    output logic              load_out,
    output logic [ACC_W-1:0]  pe_result,
    output logic              done_pe,
    output logic              overflow,
    output logic              busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ACCUM = 1'b1;

    localparam logic [c_SAT_W-1:0] c_MAX_S_FULL = sat_max(ACC_W, 1'b1);
    localparam logic [c_SAT_W-1:0] c_MIN_S_FULL = sat_min(ACC_W, 1'b1);
    localparam logic [c_SAT_W-1:0] c_MAX_U_FULL = sat_max(ACC_W, 1'b0);
    localparam logic [ACC_W:0]     c_MAX_S      = c_MAX_S_FULL[ACC_W:0];
    localparam logic [ACC_W:0]     c_MIN_S      = c_MIN_S_FULL[ACC_W:0];
    localparam logic [ACC_W:0]     c_MAX_U      = c_MAX_U_FULL[ACC_W:0];

    // ---------------------------------------------------------------- FSM
    logic [0:0]        r_state;
    logic [1:0]        r_mode_q;
    logic              r_sgn_q;
    logic [KLEN_W-1:0] r_klen_q;
    logic [KLEN_W-1:0] r_cnt;

    logic [KLEN_W-1:0] w_klen_eff;
    logic [KLEN_W-1:0] w_cnt_inc;
    logic              w_first;
    logic              w_last;
    logic [1:0]        w_mode;
    logic              w_sgn;

    // Beat tagging. The FIRST beat uses the live setup inputs, which are
    // latched at the same edge, so every beat sees the same mode/sign.
    always_comb begin
        w_klen_eff = (k_len == '0) ? KLEN_W'(1) : k_len;
        w_cnt_inc  = r_cnt + KLEN_W'(1);
        w_first    = 1'b0;
        w_last     = 1'b0;
        w_mode     = r_mode_q;
        w_sgn      = r_sgn_q;
        if (r_state == c_ST_IDLE) begin
            w_first = load_in;
            w_last  = load_in && (w_klen_eff == KLEN_W'(1));
            w_mode  = mode;
            w_sgn   = is_signed;
        end else begin
            w_last  = load_in && (w_cnt_inc == r_klen_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_mode_q <= MODE_INT8;
            r_sgn_q  <= 1'b0;
            r_klen_q <= '0;
            r_cnt    <= '0;
        end else if (load_in) begin
            if (r_state == c_ST_IDLE) begin
                r_mode_q <= mode;
                r_sgn_q  <= is_signed;
                r_klen_q <= w_klen_eff;
                r_cnt    <= KLEN_W'(1);
                r_state  <= w_last ? c_ST_IDLE : c_ST_ACCUM;
            end else begin
                r_cnt <= w_cnt_inc;
                if (w_last) begin
                    r_state <= c_ST_IDLE;
                end
            end
        end
    end

    // ------------------------------------------- S1 / systolic forwarding
    // The forwarding registers double as the S1 operand/valid registers.
    logic       r_s1_first;
    logic       r_s1_last;
    logic [1:0] r_s1_mode;
    logic       r_s1_sgn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_out    <= '0;
            col_out    <= '0;
            load_out   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mode  <= MODE_INT8;
            r_s1_sgn   <= 1'b0;
        end else begin
            row_out    <= row_in;
            col_out    <= col_in;
            load_out   <= load_in;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_mode  <= w_mode;
            r_s1_sgn   <= w_sgn;
        end
    end

    // ----------------------------------------------------------------- S2
    logic           w_s2_valid;
    logic           w_s2_first;
    logic           w_s2_last;
    logic           w_s2_sgn;
    logic [ACC_W:0] w_s2_sum;

    pe_simd_mul #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_simd_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (load_out),
        .i_first (r_s1_first),
        .i_last  (r_s1_last),
        .i_mode  (r_s1_mode),
        .i_sgn   (r_s1_sgn),
        .i_row   (row_out),
        .i_col   (col_out),
        .o_valid (w_s2_valid),
        .o_first (w_s2_first),
        .o_last  (w_s2_last),
        .o_sgn   (w_s2_sgn),
        .o_sum   (w_s2_sum)
    );

    // ----------------------------------------------------------------- S3
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_s3_valid;
    logic             r_s3_last;

    logic [ACC_W:0]   w_base;
    logic [ACC_W:0]   w_raw;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_clamp;
    logic             w_ovf_next;

    // Both addends fit in ACC_W bits of their signedness, so the ACC_W+1-bit
    // sum is exact and the clamp test can be done on it directly.
    always_comb begin
        w_base = '0;
        if (!w_s2_first) begin
            w_base = w_s2_sgn ? {r_acc[ACC_W-1], r_acc} : {1'b0, r_acc};
        end
        w_raw      = w_base + w_s2_sum;
        w_acc_next = w_raw[ACC_W-1:0];
        w_clamp    = 1'b0;
        if (w_s2_sgn) begin
            if ($signed(w_raw) > $signed(c_MAX_S)) begin
                w_acc_next = c_MAX_S[ACC_W-1:0];
                w_clamp    = 1'b1;
            end else if ($signed(w_raw) < $signed(c_MIN_S)) begin
                w_acc_next = c_MIN_S[ACC_W-1:0];
                w_clamp    = 1'b1;
            end
        end else if (w_raw > c_MAX_U) begin
            w_acc_next = c_MAX_U[ACC_W-1:0];
            w_clamp    = 1'b1;
        end
        w_ovf_next = (w_s2_first ? 1'b0 : r_ovf) | w_clamp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
        end else begin
            r_s3_valid <= w_s2_valid;
            if (w_s2_valid) begin
                r_acc     <= w_acc_next;
                r_ovf     <= w_ovf_next;
                r_s3_last <= w_s2_last;
            end
        end
    end

    // Result stage: capture the finished sum before a following FIRST beat
    // overwrites the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_result <= '0;
            overflow  <= 1'b0;
            done_pe   <= 1'b0;
        end else begin
            done_pe <= r_s3_valid & r_s3_last;
            if (r_s3_valid && r_s3_last) begin
                pe_result <= r_acc;
                overflow  <= r_ovf;
            end
        end
    end

    assign busy = (r_state == c_ST_ACCUM) | load_out | w_s2_valid | r_s3_valid;

endmodule
`default_nettype wire

// File: tb/tb_pe_int_mac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pe_int_mac
// Purpose  : Directed self-checking bench for pe_int_mac with hand-computed
//            expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_int_mac;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 64;
    localparam int KLEN_W = 16;

    logic              clk;
    logic              rst_n;
    logic              load_in;
    logic [1:0]        mode;
    logic              is_signed;
    logic [KLEN_W-1:0] k_len;
    logic [DATA_W-1:0] row_in;
    logic [DATA_W-1:0] col_in;
    logic [DATA_W-1:0] row_out;
    logic [DATA_W-1:0] col_out;
    logic              load_out;
    logic [ACC_W-1:0]  pe_result;
    logic              done_pe;
    logic              overflow;
    logic              busy;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pe_int_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .KLEN_W (KLEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_in   (load_in),
        .mode      (mode),
        .is_signed (is_signed),
        .k_len     (k_len),
        .row_in    (row_in),
        .col_in    (col_in),
        .row_out   (row_out),
        .col_out   (col_out),
        .load_out  (load_out),
        .pe_result (pe_result),
        .done_pe   (done_pe),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Present one beat; returns 1 ns after the edge that samples it.
    task automatic drive(input logic ld, input logic [1:0] m, input logic s,
                         input logic [KLEN_W-1:0] k, input logic [DATA_W-1:0] r,
                         input logic [DATA_W-1:0] c);
        load_in   = ld;
        mode      = m;
        is_signed = s;
        k_len     = k;
        row_in    = r;
        col_in    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_in   = 1'b0;
        mode      = 2'b00;
        is_signed = 1'b0;
        k_len     = '0;
        row_in    = '0;
        col_in    = '0;
    endtask

    // Counts edges until done_pe is seen, bounded by max_cycles.
    task automatic wait_done(input int max_cycles, output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= max_cycles && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_pe) begin
                seen = 1'b1;
                lat  = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pe_result !== '0) begin
            errors++;
            $display("FAIL reset_pe_result got=%h exp=0", pe_result);
        end
        checks++;
        if ({done_pe, overflow, busy, load_out} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {done_pe, overflow, busy, load_out});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_int32_signed();
        int   lat;
        logic seen;
        drive(1'b1, 2'b10, 1'b1, 16'd1, 32'd3, 32'hFFFF_FFFB);
        checks++;
        if ({row_out, col_out, load_out} !== {32'd3, 32'hFFFF_FFFB, 1'b1}) begin
            errors++;
            $display("FAIL fwd_echo got=%h/%h/%b exp=3/fffffffb/1", row_out, col_out, load_out);
        end
        idle();
        wait_done(8, lat, seen);
        checks++;
        if (!seen || lat != 3) begin
            errors++;
            $display("FAIL i32_latency seen=%b lat=%0d exp=1/3", seen, lat);
        end
        checks++;
        if (pe_result !== 64'hFFFF_FFFF_FFFF_FFF1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL i32_result got=%h ovf=%b exp=fffffffffffffff1 ovf=0", pe_result, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_pe !== 1'b0 || pe_result !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            errors++;
            $display("FAIL i32_pulse_hold done=%b res=%h exp=0/fffffffffffffff1", done_pe, pe_result);
        end
    endtask

    task automatic test_int8_signed();
        int   lat;
        logic seen;
        logic bad_busy;
        drive(1'b1, 2'b00, 1'b1, 16'd2, 32'h0102_0304, 32'h0101_0101);
        // Setup inputs are ignored mid-dot-product.
        drive(1'b1, 2'b10, 1'b0, 16'd7, 32'hFFFF_FFFF, 32'h0202_0202);
        idle();
        bad_busy = 1'b0;
        seen     = 1'b0;
        lat      = 0;
        for (int i = 1; i <= 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done_pe) begin
                seen = 1'b1;
                lat  = i;
            end else if (!busy) begin
                bad_busy = 1'b1;
            end
        end
        checks++;
        if (bad_busy !== 1'b0) begin
            errors++;
            $display("FAIL i8_busy got=dropped exp=high until done");
        end
        checks++;
        if (!seen || lat != 3 || pe_result !== 64'd2 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL i8_result seen=%b lat=%0d res=%h ovf=%b exp=1/3/2/0", seen, lat, pe_result, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL i8_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_int16_gap_b2b();
        int   lat;
        logic seen;
        drive(1'b1, 2'b01, 1'b0, 16'd3, 32'hFFFF_0001, 32'hFFFF_0001);
        drive(1'b1, 2'b01, 1'b0, 16'd3, 32'hFFFF_0001, 32'hFFFF_0001);
        idle();
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL i16_gap_busy got=%b exp=1", busy);
        end
        drive(1'b1, 2'b00, 1'b1, 16'd1, 32'hFFFF_0001, 32'hFFFF_0001);
        drive(1'b1, 2'b01, 1'b0, 16'd1, 32'h0002_0002, 32'h0002_0002);
        idle();
        wait_done(10, lat, seen);
        checks++;
        if (!seen || lat != 2 || pe_result !== 64'h2_FFFA_0006 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL i16_first seen=%b lat=%0d res=%h ovf=%b exp=1/2/2fffa0006/0", seen, lat, pe_result, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_pe !== 1'b1 || pe_result !== 64'd8) begin
            errors++;
            $display("FAIL i16_second done=%b res=%h exp=1/8", done_pe, pe_result);
        end
    endtask

    task automatic test_saturation();
        int   lat;
        logic seen;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 1'b1, 16'd3, 32'h8000_0000, 32'h8000_0000);
        end
        drive(1'b1, 2'b10, 1'b1, 16'd1, 32'd1, 32'd1);
        idle();
        wait_done(10, lat, seen);
        checks++;
        if (!seen || lat != 2 || pe_result !== 64'h7FFF_FFFF_FFFF_FFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_result seen=%b lat=%0d res=%h ovf=%b exp=1/2/7fffffffffffffff/1", seen, lat, pe_result, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_pe !== 1'b1 || pe_result !== 64'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_follow done=%b res=%h ovf=%b exp=1/1/0", done_pe, pe_result, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   n_done;
        logic seen;
        drive(1'b1, 2'b10, 1'b1, 16'd3, 32'd5, 32'd5);
        idle();
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_busy got=%b exp=1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pe_result !== '0 || {done_pe, overflow, busy, load_out} !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_clear res=%h flags=%b exp=0/0000", pe_result, {done_pe, overflow, busy, load_out});
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done_pe) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL rmid_no_done got=%0d exp=0", n_done);
        end
        drive(1'b1, 2'b10, 1'b1, 16'd1, 32'd2, 32'd3);
        idle();
        wait_done(8, lat, seen);
        checks++;
        if (!seen || lat != 3 || pe_result !== 64'd6 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_after seen=%b lat=%0d res=%h ovf=%b exp=1/3/6/0", seen, lat, pe_result, overflow);
        end
    endtask

    task automatic test_klen0();
        int   lat;
        logic seen;
        drive(1'b1, 2'b00, 1'b0, 16'd0, 32'h0000_00FF, 32'h0000_00FF);
        idle();
        wait_done(8, lat, seen);
        checks++;
        if (!seen || lat != 3 || pe_result !== 64'hFE01 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL klen0_result seen=%b lat=%0d res=%h ovf=%b exp=1/3/fe01/0", seen, lat, pe_result, overflow);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL klen0_idle busy=%b exp=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_int32_signed();
        test_int8_signed();
        test_int16_gap_b2b();
        test_saturation();
        test_reset_mid();
        test_klen0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_int_mac.md
Name: pe_int_mac

Overview:
- Parametrised integer systolic processing element; the next generation of the matrix-multiplier PE.
- Runtime-selectable SIMD int8/int16/int32 dot-product MAC with a K-beat accumulation counter.
- Fully pipelined: one operand beat accepted per cycle, back-to-back dot products without bubbles.
- Signed or unsigned operands, saturating accumulator, and registered systolic forwarding of row/col operands.

Parameters:
- DATA_W, 32: operand width; must be a multiple of 4 and at least 8.
- ACC_W, 64: accumulator and result width; must be at least 2*DATA_W.
- KLEN_W, 16: width of the k_len port.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_in  in  1  operand beat valid; no backpressure.
- mode  in  2  00 int8 (DATA_W/8 lanes), 01 int16 (DATA_W/16 lanes), 10 int32 (1 lane, DATA_W bits), 11 treated as 10.
- is_signed  in  1  1 = two's-complement lanes, 0 = unsigned.
- k_len  in  KLEN_W  beats per dot product; 0 treated as 1.
- row_in  in  DATA_W  packed row operand lanes, lane 0 in the LSBs.
- col_in  in  DATA_W  packed col operand lanes.
- row_out  out  DATA_W  registered copy of row_in.
- col_out  out  DATA_W  registered copy of col_in.
- load_out  out  1  registered copy of load_in.
- pe_result  out  ACC_W  final dot-product result; held until the next done_pe.
- done_pe  out  1  one-cycle pulse; pe_result valid in the same cycle.
- overflow  out  1  saturation occurred in the reported dot product; valid with done_pe and held alongside pe_result.
- busy  out  1  a dot product is in progress or beats are in flight in the pipeline.

Behaviour:
- Reset: all outputs, the pipeline and all counters clear to 0 asynchronously on rst_n low; FSM goes to IDLE. A reset mid-operation discards any partial sum; no done_pe is produced for the aborted dot product.
- Forwarding: row_out, col_out and load_out register row_in, col_in and load_in every cycle, regardless of FSM state (1-cycle latency).
- FSM, IDLE:
  - load_in=1 marks the beat as FIRST.
  - mode, is_signed and k_len are latched as mode_q, sgn_q and klen_q (k_len 0 latched as 1).
  - beat counter set to 1.
  - If klen_q==1 the beat is also LAST and the FSM stays in IDLE; otherwise it goes to ACCUM.
- FSM, ACCUM:
  - Each load_in=1 increments the beat counter.
  - The beat with counter==klen_q is tagged LAST; FSM returns to IDLE.
  - load_in=0 cycles are gaps and hold the counter.
  - mode, is_signed and k_len are ignored in ACCUM; the latched values apply to all beats of the dot product.
- Pipeline: each beat carries FIRST, LAST, mode_q and sgn_q tags.
  - S1: register the operands and tags.
  - S2: per-lane multiply (lane width w gives a 2w-bit product, sign- or zero-extended per sgn_q); sum all lanes; extend to ACC_W+1 bits; register.
  - S3: acc_next = (FIRST ? 0 : acc) + S2 sum, computed at ACC_W+1 bits.
    - Signed: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
    - Unsigned: clamp to [0, 2^ACC_W-1].
    - Any clamp sets the sticky ovf flag; FIRST clears ovf before this beat's check.
  - On a LAST beat at S3: pe_result <= acc_next, overflow <= ovf_next, done_pe <= 1.
- Latency: done_pe asserts in the cycle after the 3rd rising edge following the edge that samples the LAST beat.
- Throughput: a FIRST beat may immediately follow a LAST beat. Two dot products can be in flight at once without corrupting each other: the FIRST tag restarts acc.
- busy = (state==ACCUM) or any valid beat in S1, S2 or S3.
- Simultaneous events: S3 finishing LAST while S1 holds the next FIRST is legal; results stay independent.

Decomposition:
- Package pe_int_pkg holds:
  - mode encodings MODE_INT8, MODE_INT16, MODE_INT32;
  - function lanes(mode, DATA_W);
  - saturation-bound constants derived from ACC_W.
- One sub-module, pe_simd_mul: the S2 stage (lane split, signed/unsigned multiply, lane reduction, output register), parametrised by DATA_W and ACC_W.
- The FSM, counter, tags and accumulator stay in pe_int_mac.

Test Plan:
- int32 signed, k_len=1, row=3, col=0xFFFFFFFB (-5):
  - row_out/col_out/load_out echo one cycle later;
  - done_pe fires once, 3 edges after the sampling edge;
  - pe_result=0xFFFFFFFFFFFFFFF1, overflow=0.
- int8 signed, k_len=2, beat1 row=0x01020304 col=0x01010101, beat2 row=0xFFFFFFFF col=0x02020202 -> pe_result=2 (10 + -8); busy high until done_pe.
- int16 unsigned, k_len=3, beats row=col=0xFFFF0001 with one load_in gap between beats 2 and 3, then an immediate second dot product (k_len=1, row=col=0x00020002):
  - first pe_result=3*(0xFFFE0001+1)=0x2FFFA0006;
  - second pe_result=8, with done_pe exactly 1 cycle after the first.
- Saturation: int32 signed, k_len=3, row=col=0x80000000 every beat -> pe_result=0x7FFFFFFFFFFFFFFF, overflow=1; a following k_len=1 dot product 1*1 -> pe_result=1, overflow=0.
- Reset mid-operation: k_len=3, one beat of 5*5 sent, rst_n pulsed low -> all outputs 0, no done_pe; after release, k_len=1 beat 2*3 -> pe_result=6.
- k_len=0, int8 unsigned, row=0x000000FF, col=0x000000FF -> treated as a 1-beat dot product; pe_result=0xFE01.
